axi_burst_to_icb_bridge: RTL and testbench
==========================================

// Module: axi_burst_to_icb_bridge
// PURPOSE
// - AXI4 slave (32b data, no IDs) to ICB master. Each AXI burst (1..256 words) is split into single-word ICB commands.
// - Sits in front of ICB-native memories/peripherals so AXI line-fill/writeback masters (dcache/icache) can reach them.
// - Only one burst is in flight at a time. ICB commands are pipelined up to MAX_OUTSTANDING ahead of their responses.
// PARAMETERS
// - MAX_OUTSTANDING  4  max ICB cmds issued but not yet responded (1..15)
// - SIM_DELAY        1  simulation delay on registered assignments
// PORTS (name dir width meaning)
// - aclk            in   1   clock
// - areset          in   1   asynchronous reset, active high
// - s_axi_araddr / arburst / arlen             in  32/2/8   read address; size fixed 4B (no arsize port)
// - s_axi_arvalid in 1; s_axi_arready out 1                 AR handshake
// - s_axi_rdata / rresp / rlast / rvalid       out 32/2/1/1 read data
// - s_axi_rready                               in  1        read data ready
// - s_axi_awaddr / awburst / awlen             in  32/2/8   write address; size fixed 4B
// - s_axi_awvalid in 1; s_axi_awready out 1                 AW handshake
// - s_axi_wdata / wstrb / wlast / wvalid       in  32/4/1/1 write data; wlast ignored, beat count taken from awlen
// - s_axi_wready                               out 1        write data ready
// - s_axi_bresp / bvalid out 2/1; s_axi_bready in 1         write response
// - m_icb_cmd_addr / read / wdata / wmask / valid  out 32/1/32/4/1  ICB cmd
// - m_icb_cmd_ready                            in  1        ICB cmd ready
// - m_icb_rsp_rdata / err / valid              in  32/1/1   ICB rsp
// - m_icb_rsp_ready                            out 1        ICB rsp ready
// BEHAVIOUR
// - Reset state: FSM=IDLE; all valid/ready outputs 0; rresp=bresp=0; rlast=0; counters 0; arbitration priority=read.
// - FSM transitions:
//   - IDLE->RD on AR handshake; IDLE->WR on AW handshake.
//   - RD->IDLE on the R handshake with rlast=1.
//   - WR->WR_RESP on the last ICB rsp handshake.
//   - WR_RESP->IDLE on bvalid&bready.
// - IDLE address acceptance (combinational readies):
//   - arready = IDLE & (prio_rd | ~awvalid); awready = IDLE & (~prio_rd | ~arvalid).
//   - prio flips to the other direction after every accept. AR/AW are never both accepted in the same cycle.
// - Accept action: latch base/cur addr = {addr[31:2],2'b00}, len, burst; clear cmd_cnt, rsp_cnt (9b) and sticky err.
// - RD command side:
//   - m_icb_cmd_valid = (cmd_cnt<=len) & (outst<MAX_OUTSTANDING); read=1; wdata=0, wmask=0.
//   - cur addr += 4 on each cmd handshake (mod 2^32); 4KB crossing is not checked.
// - RD response side (pass-through, zero added latency):
//   - rvalid=m_icb_rsp_valid; rdata=rsp_rdata; rresp=rsp_err?2'b10:2'b00; rlast=(rsp_cnt==len).
//   - m_icb_rsp_ready=s_axi_rready.
// - WR command side:
//   - m_icb_cmd_valid = wvalid & (cmd_cnt<=len) & (outst<MAX_OUTSTANDING); wready = m_icb_cmd_ready & the same gates.
//   - read=0; wdata/wmask = wdata/wstrb.
// - WR response side: m_icb_rsp_ready=1; err |= rsp_err on every rsp handshake.
// - WR_RESP: bvalid=1, bresp = err?2'b10:2'b00, held stable until bready.
// - outst counter: +1 on cmd handshake, -1 on rsp handshake, unchanged when both occur in one cycle; never exceeds MAX_OUTSTANDING.
// - Outside RD/WR: m_icb_cmd_valid=0, m_icb_rsp_ready=0, rvalid=0, wready=0.
// - A new AR/AW is not accepted until the previous burst's last R/B handshake has completed.
// - Reset mid-burst: all state returns to reset values immediately. ICB slaves are reset together; stale rsps are not tracked.
// CONFIGURATION
// - AXI_TO_ICB_WRAP_BURST_EN defined:
//   - burst==2'b10 wraps on a (len+1)*4-byte boundary: mask=(len+1)*4-1; next = (cur & ~mask) | ((cur+4) & mask).
//   - len must be 1/3/7/15. All other burst codes behave as INCR.
// - Undefined: arburst/awburst are ignored and every burst is INCR.
// TESTING
// - AR 0x1000 len 7 INCR, slave responds 1 cycle after cmd -> ICB reads 0x1000..0x101C in order; 8 R beats; rlast on beat 8 only; rresp 0.
// - AW 0x2000 len 3, W 0xA0..0xA3 wstrb 0xF, rsp_err=1 on 3rd rsp -> 4 ICB writes; exactly one B with bresp 2'b10 after the 4th rsp.
// - MAX_OUTSTANDING=4, read len 15, slave never responds -> exactly 4 cmd handshakes, then cmd_valid stays 0.
// - AR and AW valid in the same cycle after reset -> AR accepted first, AW after the read completes; next collision serves AW first.
// - rready held low 10 cycles mid-burst -> m_icb_rsp_ready low for those cycles; no beat lost or duplicated; order preserved.
// - WRAP_EN defined: WRAP read 0x3018 len 3 -> ICB addrs 0x3018, 0x301C, 0x3010, 0x3014; macro undefined -> 0x3018..0x3024.

Source files
------------

// File: rtl/axi_burst_to_icb_bridge_if.sv
// Bus bundles used by the AXI-burst to ICB bridge.
// axi_burst_if carries the AXI4 slave side (32-bit data, no IDs, size fixed at
// 4 bytes); icb_if carries the single-word ICB command/response side.

interface axi_burst_if;
   logic [31:0] s_axi_araddr;
   logic [1:0]  s_axi_arburst;
   logic [7:0]  s_axi_arlen;
   logic        s_axi_arvalid;
   logic        s_axi_arready;

   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rlast;
   logic        s_axi_rvalid;
   logic        s_axi_rready;

   logic [31:0] s_axi_awaddr;
   logic [1:0]  s_axi_awburst;
   logic [7:0]  s_axi_awlen;
   logic        s_axi_awvalid;
   logic        s_axi_awready;

   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wlast;
   logic        s_axi_wvalid;
   logic        s_axi_wready;

   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready;

   modport slave (
      input  s_axi_araddr, s_axi_arburst, s_axi_arlen, s_axi_arvalid,
      output s_axi_arready,
      output s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
      input  s_axi_rready,
      input  s_axi_awaddr, s_axi_awburst, s_axi_awlen, s_axi_awvalid,
      output s_axi_awready,
      input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
      output s_axi_wready,
      output s_axi_bresp, s_axi_bvalid,
      input  s_axi_bready
   );

   modport master (
      output s_axi_araddr, s_axi_arburst, s_axi_arlen, s_axi_arvalid,
      input  s_axi_arready,
      input  s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
      output s_axi_rready,
      output s_axi_awaddr, s_axi_awburst, s_axi_awlen, s_axi_awvalid,
      input  s_axi_awready,
      output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
      input  s_axi_wready,
      input  s_axi_bresp, s_axi_bvalid,
      output s_axi_bready
   );
endinterface

interface icb_if;
   logic [31:0] m_icb_cmd_addr;
   logic        m_icb_cmd_read;
   logic [31:0] m_icb_cmd_wdata;
   logic [3:0]  m_icb_cmd_wmask;
   logic        m_icb_cmd_valid;
   logic        m_icb_cmd_ready;

   logic [31:0] m_icb_rsp_rdata;
   logic        m_icb_rsp_err;
   logic        m_icb_rsp_valid;
   logic        m_icb_rsp_ready;

   modport master (
      output m_icb_cmd_addr, m_icb_cmd_read, m_icb_cmd_wdata, m_icb_cmd_wmask, m_icb_cmd_valid,
      input  m_icb_cmd_ready,
      input  m_icb_rsp_rdata, m_icb_rsp_err, m_icb_rsp_valid,
      output m_icb_rsp_ready
   );

   modport slave (
      input  m_icb_cmd_addr, m_icb_cmd_read, m_icb_cmd_wdata, m_icb_cmd_wmask, m_icb_cmd_valid,
      output m_icb_cmd_ready,
      output m_icb_rsp_rdata, m_icb_rsp_err, m_icb_rsp_valid,
      input  m_icb_rsp_ready
   );
endinterface

// File: rtl/axi_burst_to_icb_bridge.sv
// AXI4 burst slave to ICB master bridge.
// One AXI burst (1..256 words) is in flight at a time and is broken into
// single-word ICB commands, pipelined up to MAX_OUTSTANDING ahead of their
// responses. Read responses pass straight through to the R channel; write
// responses are folded into a single B response with a sticky error.
// Optional feature: define AXI_TO_ICB_WRAP_BURST_EN to honour WRAP bursts
// (burst code 2'b10, len 1/3/7/15); otherwise every burst is treated as INCR.

module axi_burst_to_icb_bridge #(
   parameter int MAX_OUTSTANDING = 4,
   parameter int SIM_DELAY       = 1
) (
   input logic         aclk,
   input logic         areset,
   axi_burst_if.slave  axi,
   icb_if.master       icb
);

   typedef enum logic [1:0] {
      IDLE,
      RD,
      WR,
      WR_RESP
   } state_t;

   localparam logic [3:0] MAX_OUT = 4'(MAX_OUTSTANDING);

   state_t      state_q, state_d;
   logic        prioRd_q, prioRd_d;
   logic [31:0] curAddr_q, curAddr_d;
   logic [7:0]  len_q, len_d;
   logic [8:0]  cmdCnt_q, cmdCnt_d;
   logic [8:0]  rspCnt_q, rspCnt_d;
   logic [3:0]  outst_q, outst_d;
   logic        err_q, err_d;
`ifdef AXI_TO_ICB_WRAP_BURST_EN
   logic [1:0]  burst_q, burst_d;
   logic [31:0] wrapMask;
`endif

   logic        inRd, inWr, inResp;
   logic        arReady, awReady, arHs, awHs;
   logic        cmdGate, cmdValid, cmdHs;
   logic        rspReady, rspHs, lastRsp;
   logic [31:0] nextAddr;
   logic        unusedSink;

   assign inRd   = (state_q == RD);
   assign inWr   = (state_q == WR);
   assign inResp = (state_q == WR_RESP);

   // Address arbitration: the priority bit only matters when both AR and AW
   // are valid, and since it picks exactly one side they never both handshake.
   assign arReady = (state_q == IDLE) & (prioRd_q | ~axi.s_axi_awvalid);
   assign awReady = (state_q == IDLE) & (~prioRd_q | ~axi.s_axi_arvalid);
   assign arHs    = arReady & axi.s_axi_arvalid;
   assign awHs    = awReady & axi.s_axi_awvalid;

   // Commands stop once every beat is issued or the outstanding window is full.
   assign cmdGate  = (cmdCnt_q <= {1'b0, len_q}) & (outst_q < MAX_OUT);
   assign cmdValid = (inRd & cmdGate) | (inWr & axi.s_axi_wvalid & cmdGate);
   assign cmdHs    = cmdValid & icb.m_icb_cmd_ready;

   // Read responses are throttled by the AXI master; write responses are always taken.
   assign rspReady = inRd ? axi.s_axi_rready : inWr;
   assign rspHs    = icb.m_icb_rsp_valid & rspReady;
   assign lastRsp  = (rspCnt_q == {1'b0, len_q});

`ifdef AXI_TO_ICB_WRAP_BURST_EN
   // (len+1)*4-1 is just len with two low ones appended.
   assign wrapMask = {22'b0, len_q, 2'b11};
   assign nextAddr = (burst_q == 2'b10) ?
                     ((curAddr_q & ~wrapMask) | ((curAddr_q + 32'd4) & wrapMask)) :
                     (curAddr_q + 32'd4);
`else
   assign nextAddr = curAddr_q + 32'd4;
`endif

   assign icb.m_icb_cmd_valid = cmdValid;
   assign icb.m_icb_cmd_addr  = curAddr_q;
   assign icb.m_icb_cmd_read  = inRd;
   assign icb.m_icb_cmd_wdata = inWr ? axi.s_axi_wdata : 32'd0;
   assign icb.m_icb_cmd_wmask = inWr ? axi.s_axi_wstrb : 4'd0;
   assign icb.m_icb_rsp_ready = rspReady;

   assign axi.s_axi_arready = arReady;
   assign axi.s_axi_awready = awReady;
   assign axi.s_axi_rvalid  = inRd & icb.m_icb_rsp_valid;
   assign axi.s_axi_rdata   = icb.m_icb_rsp_rdata;
   assign axi.s_axi_rresp   = (inRd & icb.m_icb_rsp_err) ? 2'b10 : 2'b00;
   assign axi.s_axi_rlast   = inRd & lastRsp;
   assign axi.s_axi_wready  = inWr & icb.m_icb_cmd_ready & axi.s_axi_wvalid & cmdGate;
   assign axi.s_axi_bvalid  = inResp;
   assign axi.s_axi_bresp   = (inResp & err_q) ? 2'b10 : 2'b00;

   // wlast is redundant with awlen, and the low address bits are always
   // forced to word alignment, so these inputs are intentionally not consumed.
   assign unusedSink = ^{axi.s_axi_wlast, axi.s_axi_araddr[1:0], axi.s_axi_awaddr[1:0],
                         axi.s_axi_arburst, axi.s_axi_awburst, (SIM_DELAY != 0)};

   // Next-state logic: burst acceptance, beat counting, error folding and the
   // outstanding-command window all advance from the handshakes computed above.
   always_comb begin
      state_d   = state_q;
      prioRd_d  = prioRd_q;
      curAddr_d = curAddr_q;
      len_d     = len_q;
      cmdCnt_d  = cmdCnt_q;
      rspCnt_d  = rspCnt_q;
      err_d     = err_q;
      outst_d   = outst_q;
`ifdef AXI_TO_ICB_WRAP_BURST_EN
      burst_d   = burst_q;
`endif
      case (state_q)
         IDLE: begin
            if (arHs) begin
               state_d   = RD;
               prioRd_d  = 1'b0;
               curAddr_d = {axi.s_axi_araddr[31:2], 2'b00};
               len_d     = axi.s_axi_arlen;
               cmdCnt_d  = 9'd0;
               rspCnt_d  = 9'd0;
               err_d     = 1'b0;
`ifdef AXI_TO_ICB_WRAP_BURST_EN
               burst_d   = axi.s_axi_arburst;
`endif
            end else if (awHs) begin
               state_d   = WR;
               prioRd_d  = 1'b1;
               curAddr_d = {axi.s_axi_awaddr[31:2], 2'b00};
               len_d     = axi.s_axi_awlen;
               cmdCnt_d  = 9'd0;
               rspCnt_d  = 9'd0;
               err_d     = 1'b0;
`ifdef AXI_TO_ICB_WRAP_BURST_EN
               burst_d   = axi.s_axi_awburst;
`endif
            end
         end
         RD, WR: begin
            if (cmdHs) begin
               curAddr_d = nextAddr;
               cmdCnt_d  = cmdCnt_q + 9'd1;
            end
            if (rspHs) begin
               rspCnt_d = rspCnt_q + 9'd1;
               if (inWr) begin
                  err_d = err_q | icb.m_icb_rsp_err;
               end
               if (lastRsp) begin
                  state_d = inRd ? IDLE : WR_RESP;
               end
            end
         end
         WR_RESP: begin
            if (axi.s_axi_bready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      case ({cmdHs, rspHs})
         2'b10:   outst_d = outst_q + 4'd1;
         2'b01:   outst_d = outst_q - 4'd1;
         default: outst_d = outst_q;
      endcase
   end

   // State registers; reset abandons any burst in flight immediately.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q   <= IDLE;
         prioRd_q  <= 1'b1;
         curAddr_q <= 32'd0;
         len_q     <= 8'd0;
         cmdCnt_q  <= 9'd0;
         rspCnt_q  <= 9'd0;
         outst_q   <= 4'd0;
         err_q     <= 1'b0;
`ifdef AXI_TO_ICB_WRAP_BURST_EN
         burst_q   <= 2'b01;
`endif
      end else begin
         state_q   <= state_d;
         prioRd_q  <= prioRd_d;
         curAddr_q <= curAddr_d;
         len_q     <= len_d;
         cmdCnt_q  <= cmdCnt_d;
         rspCnt_q  <= rspCnt_d;
         outst_q   <= outst_d;
         err_q     <= err_d;
`ifdef AXI_TO_ICB_WRAP_BURST_EN
         burst_q   <= burst_d;
`endif
      end
   end

endmodule

// File: tb/tb_axi_burst_to_icb_bridge.sv
// Directed testbench for axi_burst_to_icb_bridge.
// A small ICB slave model answers each command one cycle later with
// rdata = addr ^ 32'h5A5A0000 and can flag an error on a chosen response.

module tb_axi_burst_to_icb_bridge;

   logic aclk;
   logic areset;

   axi_burst_if axi ();
   icb_if       icb ();

   axi_burst_to_icb_bridge #(
      .MAX_OUTSTANDING(4),
      .SIM_DELAY(1)
   ) dut (
      .aclk(aclk),
      .areset(areset),
      .axi(axi),
      .icb(icb)
   );

   int checks = 0;
   int failures = 0;

   logic [31:0] cmdAddrQ[$];
   logic        cmdReadQ[$];
   logic [31:0] cmdWdataQ[$];
   logic [3:0]  cmdMaskQ[$];
   logic [31:0] pendAddrQ[$];
   logic [31:0] rDataQ[$];
   logic        rLastQ[$];
   logic [1:0]  rRespQ[$];
   logic [1:0]  bRespQ[$];
   int          acceptQ[$];
   int          rspTotal = 0;
   int          bAtRsp = 0;
   int          errIdx = -1;
   bit          respondEn = 1'b1;

   // Free-running clock.
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Watchdog so the run always terminates.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Observe every handshake on the active edge and log it.
   always @(posedge aclk) begin
      if (!areset) begin
         if (icb.m_icb_cmd_valid && icb.m_icb_cmd_ready) begin
            cmdAddrQ.push_back(icb.m_icb_cmd_addr);
            cmdReadQ.push_back(icb.m_icb_cmd_read);
            cmdWdataQ.push_back(icb.m_icb_cmd_wdata);
            cmdMaskQ.push_back(icb.m_icb_cmd_wmask);
            pendAddrQ.push_back(icb.m_icb_cmd_addr);
         end
         if (icb.m_icb_rsp_valid && icb.m_icb_rsp_ready) begin
            if (pendAddrQ.size() > 0) pendAddrQ.delete(0);
            rspTotal++;
         end
         if (axi.s_axi_rvalid && axi.s_axi_rready) begin
            rDataQ.push_back(axi.s_axi_rdata);
            rLastQ.push_back(axi.s_axi_rlast);
            rRespQ.push_back(axi.s_axi_rresp);
         end
         if (axi.s_axi_bvalid && axi.s_axi_bready) begin
            bRespQ.push_back(axi.s_axi_bresp);
            bAtRsp = rspTotal;
         end
         if (axi.s_axi_arvalid && axi.s_axi_arready) acceptQ.push_back(0);
         if (axi.s_axi_awvalid && axi.s_axi_awready) acceptQ.push_back(1);
      end
   end

   // ICB slave response driver, updated away from the active edge.
   always @(negedge aclk) begin
      if (respondEn && pendAddrQ.size() > 0 && !areset) begin
         icb.m_icb_rsp_valid = 1'b1;
         icb.m_icb_rsp_rdata = pendAddrQ[0] ^ 32'h5A5A0000;
         icb.m_icb_rsp_err   = (rspTotal == errIdx);
      end else begin
         icb.m_icb_rsp_valid = 1'b0;
         icb.m_icb_rsp_rdata = 32'd0;
         icb.m_icb_rsp_err   = 1'b0;
      end
   end

   task automatic clearLogs();
      cmdAddrQ.delete();
      cmdReadQ.delete();
      cmdWdataQ.delete();
      cmdMaskQ.delete();
      pendAddrQ.delete();
      rDataQ.delete();
      rLastQ.delete();
      rRespQ.delete();
      bRespQ.delete();
      acceptQ.delete();
      rspTotal = 0;
      bAtRsp   = 0;
   endtask

   task automatic applyReset();
      @(negedge aclk);
      areset = 1'b1;
      axi.s_axi_arvalid = 1'b0;
      axi.s_axi_awvalid = 1'b0;
      axi.s_axi_wvalid  = 1'b0;
      clearLogs();
      repeat (3) @(negedge aclk);
      clearLogs();
      areset = 1'b0;
   endtask

   task automatic sendAr(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      int n;
      @(negedge aclk);
      axi.s_axi_araddr  = addr;
      axi.s_axi_arlen   = len;
      axi.s_axi_arburst = burst;
      axi.s_axi_arvalid = 1'b1;
      #1;
      n = 0;
      while (!axi.s_axi_arready && n < 400) begin
         @(negedge aclk);
         #1;
         n++;
      end
      checks++;
      if (axi.s_axi_arready !== 1'b1) begin
         $display("[TB] FAIL ar_accept: arready=%b required 1 for addr %h", axi.s_axi_arready, addr);
         failures++;
      end else begin
         @(posedge aclk);
      end
      #1 axi.s_axi_arvalid = 1'b0;
   endtask

   task automatic sendAw(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      int n;
      @(negedge aclk);
      axi.s_axi_awaddr  = addr;
      axi.s_axi_awlen   = len;
      axi.s_axi_awburst = burst;
      axi.s_axi_awvalid = 1'b1;
      #1;
      n = 0;
      while (!axi.s_axi_awready && n < 400) begin
         @(negedge aclk);
         #1;
         n++;
      end
      checks++;
      if (axi.s_axi_awready !== 1'b1) begin
         $display("[TB] FAIL aw_accept: awready=%b required 1 for addr %h", axi.s_axi_awready, addr);
         failures++;
      end else begin
         @(posedge aclk);
      end
      #1 axi.s_axi_awvalid = 1'b0;
   endtask

   task automatic sendW(input logic [31:0] base, input int beats);
      int n;
      for (int i = 0; i < beats; i++) begin
         @(negedge aclk);
         axi.s_axi_wdata  = base + 32'(i);
         axi.s_axi_wstrb  = 4'hF;
         axi.s_axi_wlast  = (i == beats - 1);
         axi.s_axi_wvalid = 1'b1;
         #1;
         n = 0;
         while (!axi.s_axi_wready && n < 400) begin
            @(negedge aclk);
            #1;
            n++;
         end
         if (axi.s_axi_wready !== 1'b1) begin
            checks++;
            $display("[TB] FAIL w_accept: wready=%b required 1 on beat %0d", axi.s_axi_wready, i);
            failures++;
            break;
         end
         @(posedge aclk);
      end
      #1 axi.s_axi_wvalid = 1'b0;
   endtask

   task automatic waitReads(input int count);
      int n = 0;
      while (rDataQ.size() < count && n < 300) begin
         @(negedge aclk);
         n++;
      end
      repeat (2) @(negedge aclk);
   endtask

   task automatic test_reset();
      logic [9:0] obs;
      @(negedge aclk);
      areset = 1'b1;
      #1;
      obs = {icb.m_icb_cmd_valid, icb.m_icb_rsp_ready, axi.s_axi_rvalid, axi.s_axi_rlast,
             axi.s_axi_wready, axi.s_axi_bvalid, axi.s_axi_rresp, axi.s_axi_bresp};
      checks++;
      if (obs !== 10'd0) begin
         $display("[TB] FAIL reset_outputs: got %b required 0000000000", obs);
         failures++;
      end
      repeat (2) @(negedge aclk);
      areset = 1'b0;
      #1;
      obs = {icb.m_icb_cmd_valid, icb.m_icb_rsp_ready, axi.s_axi_rvalid, axi.s_axi_rlast,
             axi.s_axi_wready, axi.s_axi_bvalid, axi.s_axi_rresp, axi.s_axi_bresp};
      checks++;
      if (obs !== 10'd0) begin
         $display("[TB] FAIL idle_outputs: got %b required 0000000000", obs);
         failures++;
      end
   endtask

   task automatic test_incr_read();
      clearLogs();
      sendAr(32'h0000_1000, 8'd7, 2'b01);
      waitReads(8);
      checks++;
      if (cmdAddrQ.size() !== 8) begin
         $display("[TB] FAIL incr_cmd_count: got %0d required 8", cmdAddrQ.size());
         failures++;
      end
      checks++;
      if (rDataQ.size() !== 8) begin
         $display("[TB] FAIL incr_beat_count: got %0d required 8", rDataQ.size());
         failures++;
      end
      for (int i = 0; i < 8; i++) begin
         if (i < cmdAddrQ.size() && i < rDataQ.size()) begin
            checks++;
            if (cmdAddrQ[i] !== 32'h1000 + 32'(4 * i) || cmdReadQ[i] !== 1'b1 ||
                rDataQ[i] !== ((32'h1000 + 32'(4 * i)) ^ 32'h5A5A0000) ||
                rLastQ[i] !== (i == 7) || rRespQ[i] !== 2'b00) begin
               $display("[TB] FAIL incr_beat%0d: got addr=%h read=%b data=%h last=%b resp=%b required addr=%h read=1 data=%h last=%b resp=00",
                        i, cmdAddrQ[i], cmdReadQ[i], rDataQ[i], rLastQ[i], rRespQ[i],
                        32'h1000 + 32'(4 * i), (32'h1000 + 32'(4 * i)) ^ 32'h5A5A0000, (i == 7));
               failures++;
            end
         end
      end
   endtask

   task automatic test_write_err();
      int n;
      clearLogs();
      errIdx = 2;
      axi.s_axi_bready = 1'b0;
      fork
         sendAw(32'h0000_2000, 8'd3, 2'b01);
         sendW(32'h0000_00A0, 4);
      join
      n = 0;
      @(negedge aclk);
      #1;
      while (!axi.s_axi_bvalid && n < 200) begin
         @(negedge aclk);
         #1;
         n++;
      end
      checks++;
      if (axi.s_axi_bvalid !== 1'b1 || axi.s_axi_bresp !== 2'b10) begin
         $display("[TB] FAIL b_first: got bvalid=%b bresp=%b required bvalid=1 bresp=10",
                  axi.s_axi_bvalid, axi.s_axi_bresp);
         failures++;
      end
      repeat (3) @(negedge aclk);
      #1;
      checks++;
      if (axi.s_axi_bvalid !== 1'b1 || axi.s_axi_bresp !== 2'b10 || bRespQ.size() !== 0) begin
         $display("[TB] FAIL b_hold: got bvalid=%b bresp=%b taken=%0d required bvalid=1 bresp=10 taken=0",
                  axi.s_axi_bvalid, axi.s_axi_bresp, bRespQ.size());
         failures++;
      end
      axi.s_axi_bready = 1'b1;
      repeat (3) @(negedge aclk);
      checks++;
      if (bRespQ.size() !== 1 || bAtRsp !== 4) begin
         $display("[TB] FAIL b_count: got count=%0d after_rsp=%0d required count=1 after_rsp=4",
                  bRespQ.size(), bAtRsp);
         failures++;
      end else begin
         checks++;
         if (bRespQ[0] !== 2'b10) begin
            $display("[TB] FAIL b_resp: got %b required 10", bRespQ[0]);
            failures++;
         end
      end
      checks++;
      if (cmdAddrQ.size() !== 4) begin
         $display("[TB] FAIL wr_cmd_count: got %0d required 4", cmdAddrQ.size());
         failures++;
      end
      for (int i = 0; i < 4; i++) begin
         if (i < cmdAddrQ.size()) begin
            checks++;
            if (cmdAddrQ[i] !== 32'h2000 + 32'(4 * i) || cmdReadQ[i] !== 1'b0 ||
                cmdWdataQ[i] !== 32'hA0 + 32'(i) || cmdMaskQ[i] !== 4'hF) begin
               $display("[TB] FAIL wr_cmd%0d: got addr=%h read=%b wdata=%h mask=%h required addr=%h read=0 wdata=%h mask=f",
                        i, cmdAddrQ[i], cmdReadQ[i], cmdWdataQ[i], cmdMaskQ[i],
                        32'h2000 + 32'(4 * i), 32'hA0 + 32'(i));
               failures++;
            end
         end
      end
      errIdx = -1;
   endtask

   task automatic test_rready_stall();
      int n;
      int badCycles;
      clearLogs();
      sendAr(32'h0000_7000, 8'd7, 2'b01);
      n = 0;
      while (rDataQ.size() < 2 && n < 100) begin
         @(negedge aclk);
         n++;
      end
      axi.s_axi_rready = 1'b0;
      badCycles = 0;
      for (int i = 0; i < 10; i++) begin
         #1;
         if (icb.m_icb_rsp_ready !== 1'b0) badCycles++;
         @(negedge aclk);
      end
      checks++;
      if (badCycles !== 0 || rDataQ.size() !== 2) begin
         $display("[TB] FAIL stall_hold: got rsp_ready_high=%0d beats=%0d required 0 and 2",
                  badCycles, rDataQ.size());
         failures++;
      end
      axi.s_axi_rready = 1'b1;
      waitReads(8);
      checks++;
      if (rDataQ.size() !== 8 || cmdAddrQ.size() !== 8) begin
         $display("[TB] FAIL stall_count: got beats=%0d cmds=%0d required 8 and 8",
                  rDataQ.size(), cmdAddrQ.size());
         failures++;
      end
      for (int i = 0; i < 8; i++) begin
         if (i < rDataQ.size()) begin
            checks++;
            if (rDataQ[i] !== ((32'h7000 + 32'(4 * i)) ^ 32'h5A5A0000) || rLastQ[i] !== (i == 7)) begin
               $display("[TB] FAIL stall_beat%0d: got data=%h last=%b required data=%h last=%b",
                        i, rDataQ[i], rLastQ[i], (32'h7000 + 32'(4 * i)) ^ 32'h5A5A0000, (i == 7));
               failures++;
            end
         end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] expAddr[4];
`ifdef AXI_TO_ICB_WRAP_BURST_EN
      expAddr[0] = 32'h3018;
      expAddr[1] = 32'h301C;
      expAddr[2] = 32'h3010;
      expAddr[3] = 32'h3014;
`else
      expAddr[0] = 32'h3018;
      expAddr[1] = 32'h301C;
      expAddr[2] = 32'h3020;
      expAddr[3] = 32'h3024;
`endif
      clearLogs();
      sendAr(32'h0000_3018, 8'd3, 2'b10);
      waitReads(4);
      checks++;
      if (cmdAddrQ.size() !== 4 || rDataQ.size() !== 4) begin
         $display("[TB] FAIL wrap_count: got cmds=%0d beats=%0d required 4 and 4",
                  cmdAddrQ.size(), rDataQ.size());
         failures++;
      end
      for (int i = 0; i < 4; i++) begin
         if (i < cmdAddrQ.size() && i < rDataQ.size()) begin
            checks++;
            if (cmdAddrQ[i] !== expAddr[i] || rDataQ[i] !== (expAddr[i] ^ 32'h5A5A0000)) begin
               $display("[TB] FAIL wrap_addr%0d: got addr=%h data=%h required addr=%h data=%h",
                        i, cmdAddrQ[i], rDataQ[i], expAddr[i], expAddr[i] ^ 32'h5A5A0000);
               failures++;
            end
         end
      end
   endtask

   task automatic test_single_err_read();
      clearLogs();
      errIdx = 0;
      sendAr(32'h0000_8003, 8'd0, 2'b01);
      waitReads(1);
      checks++;
      if (cmdAddrQ.size() !== 1 || rDataQ.size() !== 1) begin
         $display("[TB] FAIL single_count: got cmds=%0d beats=%0d required 1 and 1",
                  cmdAddrQ.size(), rDataQ.size());
         failures++;
      end else begin
         checks++;
         if (cmdAddrQ[0] !== 32'h8000 || rLastQ[0] !== 1'b1 || rRespQ[0] !== 2'b10) begin
            $display("[TB] FAIL single_beat: got addr=%h last=%b resp=%b required addr=00008000 last=1 resp=10",
                     cmdAddrQ[0], rLastQ[0], rRespQ[0]);
            failures++;
         end
      end
      errIdx = -1;
   endtask

   task automatic test_outstanding();
      clearLogs();
      respondEn = 1'b0;
      sendAr(32'h0000_6000, 8'd15, 2'b01);
      repeat (30) @(negedge aclk);
      #1;
      checks++;
      if (cmdAddrQ.size() !== 4) begin
         $display("[TB] FAIL outst_cmds: got %0d required 4", cmdAddrQ.size());
         failures++;
      end
      checks++;
      if (icb.m_icb_cmd_valid !== 1'b0 || axi.s_axi_rvalid !== 1'b0) begin
         $display("[TB] FAIL outst_stall: got cmd_valid=%b rvalid=%b required 0 and 0",
                  icb.m_icb_cmd_valid, axi.s_axi_rvalid);
         failures++;
      end
      applyReset();
      respondEn = 1'b1;
   endtask

   task automatic test_back_to_back();
      int n;
      logic [31:0] expAddr[6];
      expAddr[0] = 32'h4000;
      expAddr[1] = 32'h4004;
      expAddr[2] = 32'h5000;
      expAddr[3] = 32'h5004;
      expAddr[4] = 32'h4100;
      expAddr[5] = 32'h4104;
      applyReset();
      fork
         begin
            sendAr(32'h0000_4000, 8'd1, 2'b01);
            sendAr(32'h0000_4100, 8'd1, 2'b01);
         end
         sendAw(32'h0000_5000, 8'd1, 2'b01);
         sendW(32'h0000_00B0, 2);
      join
      n = 0;
      while ((rDataQ.size() < 4 || bRespQ.size() < 1) && n < 300) begin
         @(negedge aclk);
         n++;
      end
      repeat (2) @(negedge aclk);
      checks++;
      if (acceptQ.size() !== 3) begin
         $display("[TB] FAIL b2b_accepts: got %0d required 3", acceptQ.size());
         failures++;
      end else begin
         checks++;
         if (acceptQ[0] !== 0 || acceptQ[1] !== 1 || acceptQ[2] !== 0) begin
            $display("[TB] FAIL b2b_order: got %0d,%0d,%0d required 0,1,0 (0=AR 1=AW)",
                     acceptQ[0], acceptQ[1], acceptQ[2]);
            failures++;
         end
      end
      checks++;
      if (cmdAddrQ.size() !== 6 || bRespQ.size() !== 1) begin
         $display("[TB] FAIL b2b_counts: got cmds=%0d b=%0d required 6 and 1",
                  cmdAddrQ.size(), bRespQ.size());
         failures++;
      end
      for (int i = 0; i < 6; i++) begin
         if (i < cmdAddrQ.size()) begin
            checks++;
            if (cmdAddrQ[i] !== expAddr[i]) begin
               $display("[TB] FAIL b2b_cmd%0d: got %h required %h", i, cmdAddrQ[i], expAddr[i]);
               failures++;
            end
         end
      end
   endtask

   // Test sequence.
   initial begin
      areset = 1'b1;
      axi.s_axi_araddr  = 32'd0;
      axi.s_axi_arburst = 2'b01;
      axi.s_axi_arlen   = 8'd0;
      axi.s_axi_arvalid = 1'b0;
      axi.s_axi_rready  = 1'b1;
      axi.s_axi_awaddr  = 32'd0;
      axi.s_axi_awburst = 2'b01;
      axi.s_axi_awlen   = 8'd0;
      axi.s_axi_awvalid = 1'b0;
      axi.s_axi_wdata   = 32'd0;
      axi.s_axi_wstrb   = 4'd0;
      axi.s_axi_wlast   = 1'b0;
      axi.s_axi_wvalid  = 1'b0;
      axi.s_axi_bready  = 1'b1;
      icb.m_icb_cmd_ready = 1'b1;
      icb.m_icb_rsp_valid = 1'b0;
      icb.m_icb_rsp_rdata = 32'd0;
      icb.m_icb_rsp_err   = 1'b0;
      repeat (2) @(negedge aclk);

      test_reset();
      test_incr_read();
      test_write_err();
      test_rready_stall();
      test_wrap();
      test_single_err_read();
      test_outstanding();
      test_back_to_back();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
